// File: rtl/async_fifo_flags.sv
// Dual-clock Gray-pointer FIFO with fill levels, almost flags, sticky error flags
// and a shared asynchronous reset whose release is synchronised per domain.
`timescale 1ns/1ps
module async_fifo_flags #(
    parameter int unsigned DSIZE       = 8,
    parameter int unsigned ASIZE       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = (1 << ASIZE) - 2,
    parameter int unsigned AE_THRESH   = 2
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PW    = ASIZE + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DSIZE-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [SYNC_STAGES-1:0] wrst_sync;
    logic                   wready;
    logic [PW-1:0]          wbin;
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          wq_rptr [SYNC_STAGES];
    logic                   wen;
    logic [PW-1:0]          wbin_next;
    logic [PW-1:0]          wgray_next;
    logic [PW-1:0]          wlevel_next;
    logic                   wfull_next;
    logic                   walmost_full_next;
    logic [PW-1:0]          rptr;

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) wrst_sync <= '0;
        else         wrst_sync <= {wrst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign wready = wrst_sync[SYNC_STAGES-1];

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) wq_rptr[i] <= '0;
        end else begin
            wq_rptr[0] <= rptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) wq_rptr[i] <= wq_rptr[i-1];
        end
    end

    // Full compares against the read pointer with its two MSBs inverted.
    always_comb begin
        wen               = winc & wready & ~wfull;
        wbin_next         = wbin + PW'(wen);
        wgray_next        = (wbin_next >> 1) ^ wbin_next;
        wlevel_next       = wbin_next - gray2bin(wq_rptr[SYNC_STAGES-1]);
        wfull_next        = (wgray_next == {~wq_rptr[SYNC_STAGES-1][PW-1:PW-2],
                                            wq_rptr[SYNC_STAGES-1][PW-3:0]});
        walmost_full_next = (wlevel_next >= PW'(AF_THRESH));
    end

    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            wlevel       <= wlevel_next;
            walmost_full <= walmost_full_next;
            woverflow    <= woverflow | (winc & wready & wfull);
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) mem[wbin[ASIZE-1:0]] <= wdata;
    end

    // ---------------- read domain ----------------
    logic [SYNC_STAGES-1:0] rrst_sync;
    logic                   rready;
    logic [PW-1:0]          rbin;
    logic [PW-1:0]          rq_wptr [SYNC_STAGES];
    logic                   ren;
    logic [PW-1:0]          rbin_next;
    logic [PW-1:0]          rgray_next;
    logic [PW-1:0]          rlevel_next;
    logic                   rempty_next;
    logic                   ralmost_empty_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rrst_sync <= '0;
        else         rrst_sync <= {rrst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign rready = rrst_sync[SYNC_STAGES-1];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) rq_wptr[i] <= '0;
        end else begin
            rq_wptr[0] <= wptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) rq_wptr[i] <= rq_wptr[i-1];
        end
    end

    always_comb begin
        ren                = rinc & rready & ~rempty;
        rbin_next          = rbin + PW'(ren);
        rgray_next         = (rbin_next >> 1) ^ rbin_next;
        rlevel_next        = gray2bin(rq_wptr[SYNC_STAGES-1]) - rbin_next;
        rempty_next        = (rgray_next == rq_wptr[SYNC_STAGES-1]);
        ralmost_empty_next = (rlevel_next <= PW'(AE_THRESH));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
            rvalid        <= 1'b0;
            rdata         <= '0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= rempty_next;
            rlevel        <= rlevel_next;
            ralmost_empty <= ralmost_empty_next;
            runderflow    <= runderflow | (rinc & rready & rempty);
            rvalid        <= ren;
            if (ren) rdata <= mem[rbin[ASIZE-1:0]];
        end
    end

endmodule

// File: tb/tb_async_fifo_flags.sv
// Randomised scoreboard bench for async_fifo_flags: queue reference model for data,
// directed checks for levels, flags, crossing latency and reset behaviour.
`timescale 1ns/1ps
module tb_async_fifo_flags;

    logic       wclk, rclk, rrst_n;
    logic       winc, rinc;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, woverflow;
    logic       rvalid, rempty, ralmost_empty, runderflow;
    logic [4:0] wlevel, rlevel;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [7:0] sb [$];

    async_fifo_flags #(
        .DSIZE(8), .ASIZE(4), .SYNC_STAGES(2), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .wclk(wclk), .rclk(rclk), .rrst_n(rrst_n),
        .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow),
        .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
    );

    // Edges never coincide: wclk on integer ns, rclk on x.3/x.8 ns.
    initial begin wclk = 1'b0; forever #5 wclk = ~wclk; end
    initial begin rclk = 1'b0; #1.3; forever #8.5 rclk = ~rclk; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected word.
    initial begin
        forever begin
            @(posedge rclk);
            #1;
            if (rvalid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata_unexpected: got %0h expected no output", rdata);
                end else begin
                    chk("rdata", 32'(rdata), 32'(sb.pop_front()));
                end
                n_pop++;
            end
        end
    end

    task automatic wr(input logic [7:0] d, input bit accept);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        if (accept) sb.push_back(d);
        @(posedge wclk);
        #1;
        winc = 1'b0;
    endtask

    task automatic rd();
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
    endtask

    task automatic check_rst_vals(input string tag);
        chk({tag, "_wfull"},         32'(wfull),         32'd0);
        chk({tag, "_walmost_full"},  32'(walmost_full),  32'd0);
        chk({tag, "_wlevel"},        32'(wlevel),        32'd0);
        chk({tag, "_woverflow"},     32'(woverflow),     32'd0);
        chk({tag, "_rdata"},         32'(rdata),         32'd0);
        chk({tag, "_rvalid"},        32'(rvalid),        32'd0);
        chk({tag, "_rempty"},        32'(rempty),        32'd1);
        chk({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
        chk({tag, "_rlevel"},        32'(rlevel),        32'd0);
        chk({tag, "_runderflow"},    32'(runderflow),    32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge wclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check_rst_vals(tag);
        sb.delete();
        #20;
        rrst_n = 1'b1;
        repeat (6) @(negedge wclk);
    endtask

    initial begin
        int target;
        int wr_cnt;
        int guard;
        bit got;

        rrst_n = 1'b0;
        winc   = 1'b0;
        rinc   = 1'b0;
        wdata  = '0;
        #20;
        check_rst_vals("reset");
        @(negedge wclk);
        #2;
        rrst_n = 1'b1;
        repeat (6) @(negedge wclk);

        // Crossing latency of the first write to rempty falling.
        fork
            begin
                int cnt;
                bit found;
                cnt   = 0;
                found = 1'b0;
                do @(posedge wclk); while (!winc);
                for (int e = 1; e <= 10 && !found; e++) begin
                    @(posedge rclk);
                    #1;
                    if (!rempty) begin
                        found = 1'b1;
                        cnt   = e;
                    end
                end
                total++;
                if (!found || cnt < 3 || cnt > 4) begin
                    bad++;
                    $display("FAIL rempty_latency: got %0d rclk edges expected 3..4", cnt);
                end
            end
        join_none

        // Fill with no reads: level, almost-full and full are exact.
        for (int k = 1; k <= 16; k++) begin
            wr(8'(k), 1'b1);
            chk("fill_wlevel", 32'(wlevel), 32'(k));
            chk("fill_walmost_full", 32'(walmost_full), 32'(k >= 14));
            chk("fill_wfull", 32'(wfull), 32'(k == 16));
        end

        // Write while full is dropped and flagged.
        wr(8'hAA, 1'b0);
        chk("ovf_woverflow", 32'(woverflow), 32'd1);
        chk("ovf_wlevel", 32'(wlevel), 32'd16);
        chk("ovf_wfull", 32'(wfull), 32'd1);
        repeat (5) @(posedge wclk);
        #1;
        chk("ovf_sticky", 32'(woverflow), 32'd1);

        // Drain: read side sees exact levels since the writer is idle.
        repeat (6) @(posedge rclk);
        #1;
        chk("drain_rlevel_start", 32'(rlevel), 32'd16);
        chk("drain_rempty_start", 32'(rempty), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            rd();
            chk("drain_rvalid", 32'(rvalid), 32'd1);
            chk("drain_rlevel", 32'(rlevel), 32'(16 - k));
            chk("drain_ralmost_empty", 32'(ralmost_empty), 32'((16 - k) <= 2));
            chk("drain_rempty", 32'(rempty), 32'(k == 16));
        end

        // Read on empty.
        rd();
        chk("udf_runderflow", 32'(runderflow), 32'd1);
        chk("udf_rvalid", 32'(rvalid), 32'd0);
        chk("udf_rdata_hold", 32'(rdata), 32'h10);
        chk("udf_rempty", 32'(rempty), 32'd1);
        repeat (3) @(posedge rclk);
        #1;
        chk("udf_sticky", 32'(runderflow), 32'd1);
        chk("ovf_still_sticky", 32'(woverflow), 32'd1);

        pulse_reset("clr");

        // Random-duty streaming across pointer wrap.
        target = n_pop + 100;
        fork
            begin
                wr_cnt = 0;
                guard  = 0;
                while (wr_cnt < 100 && guard < 20000) begin
                    @(negedge wclk);
                    guard++;
                    if (!wfull && $urandom_range(0, 99) < 60) begin
                        winc  = 1'b1;
                        wdata = 8'(wr_cnt);
                        sb.push_back(8'(wr_cnt));
                        wr_cnt++;
                    end else begin
                        winc = 1'b0;
                    end
                end
                @(negedge wclk);
                winc = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (n_pop < target && g < 20000) begin
                    @(negedge rclk);
                    g++;
                    rinc = !rempty && ($urandom_range(0, 99) < 50);
                end
                rinc = 1'b0;
            end
        join
        chk("stream_writes", 32'(wr_cnt), 32'd100);
        chk("stream_reads", 32'(n_pop), 32'(target));
        chk("stream_woverflow", 32'(woverflow), 32'd0);
        chk("stream_runderflow", 32'(runderflow), 32'd0);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Store 9 entries, then reset mid-stream.
        for (int k = 0; k < 9; k++) wr(8'hC0 + 8'(k), 1'b1);
        repeat (8) @(posedge rclk);
        #1;
        chk("mid_rlevel", 32'(rlevel), 32'd9);
        chk("mid_wlevel", 32'(wlevel), 32'd9);
        pulse_reset("mid");

        wr(8'h5A, 1'b1);
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 20) begin
            @(negedge rclk);
            guard++;
            got = !rempty;
        end
        chk("post_rst_not_empty", 32'(got), 32'd1);
        rd();
        chk("post_rst_rvalid", 32'(rvalid), 32'd1);
        chk("post_rst_rdata", 32'(rdata), 32'h5A);
        repeat (4) @(posedge rclk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_rempty", 32'(rempty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_flags.md
Name: async_fifo_flags

Overview:
- Parametrised dual-clock FIFO; successor to the basic Gray-pointer async FIFO.
- Adds a configurable synchroniser depth, fill-level outputs in both domains, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags, a registered read-data port, and one shared reset with per-domain synchronised deassertion.
- Sits between clock domains on streaming datapaths (e.g. ADC capture to processing clock).

Parameters:
- DSIZE, 8, data word width.
- ASIZE, 4, address bits; DEPTH = 2**ASIZE; legal range ASIZE >= 2.
- SYNC_STAGES, 2, flops per Gray-pointer and reset synchroniser; legal range 2..4.
- AF_THRESH, DEPTH-2, walmost_full asserts when wlevel >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, ralmost_empty asserts when rlevel <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- wclk  in  1  write clock.
- rclk  in  1  read clock.
- rrst_n  in  1  reset; asynchronous, active-low; resets both domains.
- winc  in  1  write request (wclk).
- wdata  in  DSIZE  write data (wclk).
- wfull  out  1  FIFO full (wclk).
- walmost_full  out  1  wlevel >= AF_THRESH (wclk).
- wlevel  out  ASIZE+1  write-side fill estimate, range 0..DEPTH (wclk).
- woverflow  out  1  sticky: write attempted while full (wclk).
- rinc  in  1  read request (rclk).
- rdata  out  DSIZE  registered read data (rclk).
- rvalid  out  1  rdata updated this cycle (rclk).
- rempty  out  1  FIFO empty (rclk).
- ralmost_empty  out  1  rlevel <= AE_THRESH (rclk).
- rlevel  out  ASIZE+1  read-side fill estimate, range 0..DEPTH (rclk).
- runderflow  out  1  sticky: read attempted while empty (rclk).

Behaviour:
- Reset: clock wclk; reset rrst_n, asynchronous, active-low.
  - rrst_n assertion immediately clears all pointers and synchronisers in both domains.
  - Reset output values: wfull=0, walmost_full=0 (1 if AF_THRESH=0 is illegal, so always 0), wlevel=0, woverflow=0, rdata=0, rvalid=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
  - Deassertion is synchronised separately into each domain through SYNC_STAGES flops.
  - Each domain leaves reset SYNC_STAGES edges of its own clock after rrst_n rises; winc/rinc are ignored before that.
  - Memory contents are not reset.
- Pointers:
  - Binary+Gray pointers, ASIZE+1 bits each.
  - Binary pointer addresses memory; Gray pointer is registered and crosses domains through SYNC_STAGES flops.
- Write:
  - On wclk edge with winc=1 and wfull=0: mem[waddr] <= wdata, pointer increments.
  - With wfull=1: no write, no pointer change, woverflow <= 1.
- Read:
  - On rclk edge with rinc=1 and rempty=0: rdata <= mem[raddr], rvalid <= 1, pointer increments. Read latency is 1 rclk.
  - Otherwise rvalid <= 0 and rdata holds.
  - With rinc=1 and rempty=1: runderflow <= 1.
- Full: wfull is registered; it is 1 when the next write Gray pointer equals the synchronised read Gray pointer with its two MSBs inverted.
- Empty: rempty is registered; it is 1 when the next read Gray pointer equals the synchronised write Gray pointer.
- Levels:
  - wlevel = wbin - bin(synced rptr), computed modulo 2**(ASIZE+1) and registered alongside wfull.
  - rlevel = bin(synced wptr) - rbin, registered alongside rempty.
  - Both levels are conservative: wlevel never under-reports, rlevel never over-reports.
  - wlevel = DEPTH exactly when wfull=1; rlevel = 0 exactly when rempty=1.
- Almost flags: registered from next-state level each cycle, same timing as wfull/rempty.
- Crossing latency:
  - A write makes rempty fall SYNC_STAGES+1 to SYNC_STAGES+2 rclk edges after the wclk edge.
  - A read makes wfull fall SYNC_STAGES+1 to SYNC_STAGES+2 wclk edges after the rclk edge.
- Wrap-around: pointers wrap modulo 2**(ASIZE+1); the MSB distinguishes full from empty. Continuous streaming across wrap must be lossless.
- Simultaneous events:
  - A write and a read in the same cycle in either domain is legal; each domain only sees the other's pointer late, so flags remain safe.
  - Write on the cycle wfull falls is accepted.
- Sticky flags clear only on rrst_n.
- Reset mid-operation: all in-flight data is discarded; flags return to reset values within the asynchronous assertion.

Test Plan (DSIZE=8, ASIZE=4, SYNC_STAGES=2, AF_THRESH=14, AE_THRESH=2; wclk 10 ns, rclk 17 ns):
- Reset release, then write 0x01..0x10 with no reads.
  - wlevel steps 1..16; walmost_full=1 from wlevel=14; wfull=1 after the 16th write.
  - rempty falls 3-4 rclk edges after the first write.
- FIFO full, then a 17th write of 0xAA -> woverflow=1 and stays 1; the 0xAA data is never read out.
- Drain the 16 entries.
  - rdata = 0x01..0x10 in order, each with rvalid=1 one rclk after rinc.
  - ralmost_empty=1 once rlevel <= 2; rempty=1 after the last read.
- Read on empty -> runderflow=1; rdata holds 0x10; rvalid=0.
- Stream 100 words (incrementing 0x00..0x63) with random winc/rinc duty and both pointers wrapping -> output sequence identical, no overflow or underflow flagged.
- Assert rrst_n low mid-stream with 9 entries stored.
  - Immediately: wfull=0, rempty=1, wlevel=rlevel=0, sticky flags=0, rdata=0.
  - After release, first new write 0x5A reads back as 0x5A.
